division_ctrl: RTL and testbench
================================

# division_ctrl

Sequencing controller that sits directly upstream of the combinational `division` unit. On `start` it walks a block of `count` operand pairs in a synchronous-read operand RAM and presents each pair to the divider on registered `div_dividendo`/`div_divisor` lines. It captures `resultado`/`residuo` one cycle later and writes them, with a divide-by-zero flag, to a result RAM port. It turns the divider into a batch engine with a start/busy/done handshake.

## Interface

Parameters:
- `N`, 19: operand/result width; must match the `division` instance.
- `ADDR_W`, 8: operand/result RAM address width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a batch; sampled only in IDLE.
- `count`  in  ADDR_W  number of pairs; sampled with `start`.
- `mem_rd_en`  out  1  operand RAM read strobe.
- `mem_addr`  out  ADDR_W  operand RAM address.
- `mem_dividendo`  in  N  operand RAM read data; valid one cycle after the `mem_rd_en` cycle.
- `mem_divisor`  in  N  operand RAM read data; same timing as `mem_dividendo`.
- `div_dividendo`  out  N  registered dividend to the `division` unit.
- `div_divisor`  out  N  registered divisor to the `division` unit.
- `div_resultado`  in  N  quotient from the `division` unit (combinational).
- `div_residuo`  in  N  remainder from the `division` unit (combinational).
- `wr_en`  out  1  result RAM write strobe.
- `wr_addr`  out  ADDR_W  result address; equals the operand index.
- `wr_resultado`  out  N  quotient written to the result RAM.
- `wr_residuo`  out  N  remainder written to the result RAM.
- `wr_div_cero`  out  1  the written pair had divisor == 0.
- `busy`  out  1  a batch is in progress.
- `done`  out  1  one-cycle pulse at batch end.
- `err_count`  out  ADDR_W  divide-by-zero count for the current/last batch; saturating.

## Operation

- States:
  - IDLE -> RD on `start`, or -> DONE if `count` == 0.
  - RD -> LOAD -> EXEC -> WR.
  - WR -> RD if more pairs remain, else -> DONE.
  - DONE -> IDLE.
- IDLE: on `start`, latch `count`, clear the index `i` and `err_count`.
- RD: `mem_rd_en` = 1, `mem_addr` = i.
- LOAD: register `mem_dividendo`/`mem_divisor` into `div_dividendo`/`div_divisor`.
- EXEC: the divider settles; capture `div_resultado`/`div_residuo` at the end of the cycle.
- Divide-by-zero override at capture: if `div_divisor` == 0, the controller ignores the unit outputs. It forces quotient = all ones and remainder = `div_dividendo`, sets `wr_div_cero`, and increments `err_count` (saturates at all ones).
- WR: `wr_en` = 1, `wr_addr` = i; `i` increments at the end of WR.
- Index width: `i` is ADDR_W+1 bits, so `count` = 2^ADDR_W−1 does not wrap. Addresses use the low ADDR_W bits.
- `start` in any non-IDLE state is ignored; `count` changes during a batch are ignored.
- Reset values: all outputs 0, `err_count` 0, state IDLE.
- Reset mid-batch: the block returns to IDLE immediately, with no further writes and no `done`.

## Timing

- Cycle 0: IDLE with `start` = 1.
- Element k occupies cycles 4k+1 (RD) through 4k+4 (WR).
- `busy` is high in cycles 1..4·count.
- `done` is high in cycle 4·count+1, with `busy` low in that cycle.
- `count` = 0: `done` is high in cycle 1; `busy` is never asserted and no writes occur.
- Throughput: 4 cycles per pair.
- Back-to-back batches: a `start` in the cycle after DONE (IDLE) is accepted.
- `mem_rd_en`, `wr_en` and `done` are single-cycle strobes.
- `wr_*` data is registered and stable only while `wr_en` = 1; its value at other times is don't-care.

## Structure

- Shared package `division_pkg`:
  - default `N` = 19;
  - state enum `div_ctrl_state_t` {IDLE, RD, LOAD, EXEC, WR, DONE};
  - constant `DIV_CERO_Q` = all ones, used for the divide-by-zero quotient.
- No sub-module. The `division` unit is instantiated beside `division_ctrl` at the level above, and the bench instantiates both.

## Test plan

- Single pair 25/5 (`count` = 1) -> write at addr 0: quotient 5, remainder 0; `done` in cycle 5.
- Pairs {28/13, 37/6, 25/5} -> quotient/remainder 2/2, 6/1, 5/0 at addrs 0..2; `done` in cycle 13; `err_count` 0.
- Pair 40/0 -> quotient 0x7FFFF, remainder 40, `wr_div_cero` = 1; `err_count` 1.
- `count` = 0 -> `done` in cycle 1, no `wr_en`, `busy` never high.
- 524287/1 and 3/524287 -> quotient/remainder 524287/0 and 0/3.
- Reset mid-batch: assert `rst_n` low in cycle 6 of a 3-pair batch -> outputs 0 asynchronously, no `done`. A new `start` after reset runs the full batch correctly.

Source files
------------

// File: rtl/division_pkg.sv
// division_pkg: shared types and constants for the division unit and its batch controller
package division_pkg;
  localparam int DIV_N = 19;
  localparam logic [63:0] DIV_CERO_Q = '1;
  typedef enum logic [2:0] {IDLE, RD, LOAD, EXEC, WR, DONE} div_ctrl_state_t;
endpackage

// File: rtl/division_ctrl.sv
// division_ctrl: batch sequencer feeding operand pairs from RAM through the division unit into a result RAM
module division_ctrl
  import division_pkg::*;
#(
  parameter int N      = DIV_N,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [N-1:0]      mem_dividendo,
  input  logic [N-1:0]      mem_divisor,
  output logic [N-1:0]      div_dividendo,
  output logic [N-1:0]      div_divisor,
  input  logic [N-1:0]      div_resultado,
  input  logic [N-1:0]      div_residuo,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [N-1:0]      wr_resultado,
  output logic [N-1:0]      wr_residuo,
  output logic              wr_div_cero,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] err_count
);
  div_ctrl_state_t r_state, w_next;
  logic [ADDR_W:0] r_cnt, r_i;
  logic [N-1:0] r_dd, r_dv, r_q, r_r;
  logic r_dz;
  logic [ADDR_W-1:0] r_err;
  logic w_cero, w_more;
  assign w_cero = r_dv == '0;
  assign w_more = (r_i + 1'b1) < r_cnt;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = start ? ((count == '0) ? DONE : RD) : IDLE;
      RD:   w_next = LOAD;
      LOAD: w_next = EXEC;
      EXEC: w_next = WR;
      WR:   w_next = w_more ? RD : DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_i     <= '0;
      r_dd    <= '0;
      r_dv    <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_cnt <= {1'b0, count};
        r_i   <= '0;
        r_err <= '0;
      end
      if (r_state == LOAD) begin
        r_dd <= mem_dividendo;
        r_dv <= mem_divisor;
      end
      // a zero divisor bypasses the unit: its outputs are undefined in that case
      if (r_state == EXEC) begin
        r_q  <= w_cero ? N'(DIV_CERO_Q) : div_resultado;
        r_r  <= w_cero ? r_dd : div_residuo;
        r_dz <= w_cero;
        if (w_cero && r_err != '1) r_err <= r_err + 1'b1;
      end
      if (r_state == WR) r_i <= r_i + 1'b1;
    end
  end
  assign mem_rd_en     = r_state == RD;
  assign mem_addr      = mem_rd_en ? r_i[ADDR_W-1:0] : '0;
  assign div_dividendo = r_dd;
  assign div_divisor   = r_dv;
  assign wr_en         = r_state == WR;
  assign wr_addr       = wr_en ? r_i[ADDR_W-1:0] : '0;
  assign wr_resultado  = r_q;
  assign wr_residuo    = r_r;
  assign wr_div_cero   = r_dz;
  assign busy          = r_state inside {RD, LOAD, EXEC, WR};
  assign done          = r_state == DONE;
  assign err_count     = r_err;
endmodule

// File: tb/tb_division_ctrl.sv
// tb_division_ctrl: scoreboard bench for the division batch controller with a behavioural divider beside it
module tb_division_ctrl;
  localparam int N = 19;
  localparam int AW = 8;
  typedef struct {
    logic [AW-1:0] a;
    logic [N-1:0]  q;
    logic [N-1:0]  r;
    logic          dz;
  } exp_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [AW-1:0] count = '0;
  logic mem_rd_en, wr_en, wr_div_cero, busy, done;
  logic [AW-1:0] mem_addr, wr_addr, err_count;
  logic [N-1:0] mem_dividendo = '0, mem_divisor = '0;
  logic [N-1:0] div_dividendo, div_divisor, div_resultado, div_residuo, wr_resultado, wr_residuo;
  logic [N-1:0] opa [0:255];
  logic [N-1:0] opb [0:255];
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  division_ctrl #(.N(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_dividendo(mem_dividendo), .mem_divisor(mem_divisor),
    .div_dividendo(div_dividendo), .div_divisor(div_divisor),
    .div_resultado(div_resultado), .div_residuo(div_residuo),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_resultado(wr_resultado),
    .wr_residuo(wr_residuo), .wr_div_cero(wr_div_cero),
    .busy(busy), .done(done), .err_count(err_count)
  );
  // stand-in for the division unit; garbage on a zero divisor so the override is visible
  assign div_resultado = (div_divisor == '0) ? 19'h12345 : div_dividendo / div_divisor;
  assign div_residuo   = (div_divisor == '0) ? 19'h54321 : div_dividendo % div_divisor;
  always @(posedge clk) if (mem_rd_en) begin
    mem_dividendo <= opa[mem_addr];
    mem_divisor   <= opb[mem_addr];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (wr_en) begin
    if (sb.size() == 0) check("unexpected_wr", 32'(wr_addr), 32'hFFFF_FFFF);
    else begin
      exp_t e;
      e = sb.pop_front();
      check("wr_addr", 32'(wr_addr), 32'(e.a));
      check("wr_q", 32'(wr_resultado), 32'(e.q));
      check("wr_r", 32'(wr_residuo), 32'(e.r));
      check("wr_dz", 32'(wr_div_cero), 32'(e.dz));
    end
  end
  task automatic start_batch(input int n);
    @(negedge clk);
    start = 1;
    count = AW'(n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.a  = AW'(k);
      e.dz = opb[k] == '0;
      e.q  = e.dz ? 19'h7FFFF : opa[k] / opb[k];
      e.r  = e.dz ? opa[k] : opa[k] % opb[k];
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 0;
    count = 8'hAA;
  endtask
  task automatic run_batch(input int n, input int exp_err);
    start_batch(n);
    for (int c = 1; c <= 4 * n + 3; c++) begin
      @(negedge clk);
      check($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= 4 * n));
      check($sformatf("done_c%0d", c), 32'(done), 32'(c == 4 * n + 1));
      start = (n > 0 && c == 2);
    end
    start = 0;
    check("err_count", 32'(err_count), 32'(exp_err));
    check("sb_drained", 32'(sb.size()), 0);
  endtask
  initial begin
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_div_dd", 32'(div_dividendo), 0);
    @(negedge clk);
    rst_n = 1;
    opa[0] = 25; opb[0] = 5;
    run_batch(1, 0);
    opa[0] = 28; opb[0] = 13;
    opa[1] = 37; opb[1] = 6;
    opa[2] = 25; opb[2] = 5;
    run_batch(3, 0);
    opa[0] = 40; opb[0] = 0;
    run_batch(1, 1);
    run_batch(0, 0);
    opa[0] = 524287; opb[0] = 1;
    opa[1] = 3;      opb[1] = 524287;
    opa[2] = 7;      opb[2] = 0;
    opa[3] = 100;    opb[3] = 7;
    run_batch(4, 1);
    opa[0] = 28; opb[0] = 13;
    opa[1] = 37; opb[1] = 6;
    opa[2] = 40; opb[2] = 0;
    start_batch(3);
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rd_en", 32'(mem_rd_en), 0);
    check("mid_rst_div_dd", 32'(div_dividendo), 0);
    check("mid_rst_err", 32'(err_count), 0);
    sb.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mid_rst_done", 32'(done), 0);
      check("mid_rst_wr_en", 32'(wr_en), 0);
    end
    rst_n = 1;
    run_batch(3, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
